// File: rtl/bitcoin_pkg.sv
// Shared types and constants for the bitcoin job controller.
package bitcoin_pkg;

  localparam int unsigned MSG_WORDS = 19;
  localparam int unsigned NUM_NONCE = 16;

  typedef logic [31:0] word_t;
  typedef logic [15:0] addr_t;
  typedef logic [3:0]  nonce_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWait,
    StScan,
    StReport
  } state_e;

endpackage

// File: rtl/bitcoin_job_ctrl_if.sv
// Core start/done handshake plus the controller side of the shared memory port.
interface bitcoin_job_ctrl_if;
  import bitcoin_pkg::*;

  logic  core_start;
  logic  core_done;
  addr_t core_message_addr;
  addr_t core_output_addr;
  logic  core_mem_sel;
  logic  mem_we;
  addr_t mem_addr;
  word_t mem_write_data;
  word_t mem_read_data;

  modport master (
    output core_start, core_message_addr, core_output_addr, core_mem_sel,
    output mem_we, mem_addr, mem_write_data,
    input  core_done, mem_read_data
  );

  modport slave (
    input  core_start, core_message_addr, core_output_addr, core_mem_sel,
    input  mem_we, mem_addr, mem_write_data,
    output core_done, mem_read_data
  );

endinterface

// File: rtl/hash_min_tracker.sv
// Running unsigned minimum over a stream of H0 words; ties keep the earlier index.
// min_o/index_o already include the word presented this cycle.
module hash_min_tracker
  import bitcoin_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   clear_i,
  input  logic   valid_i,
  input  word_t  data_i,
  input  nonce_t index_i,
  output word_t  min_o,
  output nonce_t index_o
);

  logic   have_q, have_d;
  word_t  min_q, min_d;
  nonce_t idx_q, idx_d;
  logic   take;

  // First valid word seeds the minimum; later words replace it only when strictly smaller.
  always_comb begin
    take   = valid_i && (!have_q || (data_i < min_q));
    min_d  = take ? data_i  : min_q;
    idx_d  = take ? index_i : idx_q;
    have_d = clear_i ? 1'b0 : (have_q | valid_i);
  end

  assign min_o   = min_d;
  assign index_o = idx_d;

  // Tracker state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      have_q <= 1'b0;
      min_q  <= '0;
      idx_q  <= '0;
    end else begin
      have_q <= have_d;
      min_q  <= min_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/bitcoin_job_ctrl.sv
// Host-side job controller: loads a header into shared memory, kicks the hash core,
// then scans the per-nonce H0 results and reports the minimum.
module bitcoin_job_ctrl
  import bitcoin_pkg::*;
#(
  parameter addr_t       MSG_BASE = 16'h0000,
  parameter addr_t       OUT_BASE = 16'h0020,
  parameter int unsigned TIMEOUT  = 4000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  word_t              in_data,
  input  word_t              target,
  bitcoin_job_ctrl_if.master core_if,
  output logic               res_valid,
  input  logic               res_ready,
  output nonce_t             res_nonce,
  output word_t              res_hash,
  output logic               res_found,
  output logic               res_timeout,
  output logic               busy
);

  localparam logic [15:0] MsgWords = 16'(MSG_WORDS);
  localparam logic [15:0] NumNonce = 16'(NUM_NONCE);
  localparam logic [15:0] TimeoutC = 16'(TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;  // header index / cycles since start / scan step
  word_t       target_q, target_d;
  logic        in_ready_q, in_ready_d;
  logic        mem_we_q, mem_we_d;
  addr_t       mem_addr_q, mem_addr_d;
  word_t       mem_wdata_q, mem_wdata_d;
  nonce_t      res_nonce_q, res_nonce_d;
  word_t       res_hash_q, res_hash_d;
  logic        res_found_q, res_found_d;
  logic        res_timeout_q, res_timeout_d;
  logic        accept, trk_clear, trk_valid;
  word_t       trk_min;
  nonce_t      trk_index, trk_idx_out;

  assign accept  = in_valid & in_ready_q;
  assign cnt_inc = cnt_q + 16'd1;

  hash_min_tracker u_tracker (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (trk_clear),
    .valid_i (trk_valid),
    .data_i  (core_if.mem_read_data),
    .index_i (trk_index),
    .min_o   (trk_min),
    .index_o (trk_idx_out)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StLoad;
      StLoad:   if (cnt_q == MsgWords) state_d = StStart;  // last write is on the bus this cycle
      StStart:  state_d = StWait;
      StWait: begin
        if (core_if.core_done)       state_d = StScan;
        else if (cnt_inc == TimeoutC) state_d = StReport;
      end
      StScan:   if (cnt_q == NumNonce) state_d = StReport;
      StReport: if (res_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    core_if.core_start   = (state_q == StStart);
    core_if.core_mem_sel = (state_q == StStart) || (state_q == StWait);
    busy                 = (state_q != StIdle);
    res_valid            = (state_q == StReport);
  end

  // Counter, memory port and result next-state values.
  always_comb begin
    cnt_d         = cnt_q;
    target_d      = target_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = '0;
    mem_wdata_d   = '0;
    res_nonce_d   = res_nonce_q;
    res_hash_d    = res_hash_q;
    res_found_d   = res_found_q;
    res_timeout_d = res_timeout_q;
    trk_clear     = 1'b0;
    trk_valid     = 1'b0;
    trk_index     = 4'(cnt_q - 16'd1);
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (accept) begin
          target_d    = target;
          mem_we_d    = 1'b1;
          mem_addr_d  = MSG_BASE;
          mem_wdata_d = in_data;
          cnt_d       = 16'd1;
        end
      end
      StLoad: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = MSG_BASE + cnt_q;
          mem_wdata_d = in_data;
          cnt_d       = cnt_inc;
        end
      end
      StStart: cnt_d = 16'd1;  // counts cycles since the start pulse
      StWait: begin
        cnt_d = cnt_inc;
        if (core_if.core_done) begin
          cnt_d      = '0;
          mem_addr_d = OUT_BASE;  // first read address is live on the first scan cycle
        end else if (cnt_inc == TimeoutC) begin
          res_nonce_d   = '0;
          res_hash_d    = '0;
          res_found_d   = 1'b0;
          res_timeout_d = 1'b1;
        end
      end
      StScan: begin
        cnt_d     = cnt_inc;
        trk_clear = (cnt_q == 16'd0);
        trk_valid = (cnt_q != 16'd0);
        if (cnt_inc < NumNonce) mem_addr_d = OUT_BASE + cnt_inc;
        if (cnt_q == NumNonce) begin
          res_nonce_d   = trk_idx_out;
          res_hash_d    = trk_min;
          res_found_d   = (trk_min < target_q);
          res_timeout_d = 1'b0;
        end
      end
      StReport: cnt_d = '0;
      default:  cnt_d = '0;
    endcase
    in_ready_d = (state_d == StIdle) || ((state_d == StLoad) && (cnt_d < MsgWords));
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      target_q      <= '0;
      in_ready_q    <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      res_nonce_q   <= '0;
      res_hash_q    <= '0;
      res_found_q   <= 1'b0;
      res_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      target_q      <= target_d;
      in_ready_q    <= in_ready_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      res_nonce_q   <= res_nonce_d;
      res_hash_q    <= res_hash_d;
      res_found_q   <= res_found_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  assign in_ready                  = in_ready_q;
  assign core_if.mem_we            = mem_we_q;
  assign core_if.mem_addr          = mem_addr_q;
  assign core_if.mem_write_data    = mem_wdata_q;
  assign core_if.core_message_addr = MSG_BASE;
  assign core_if.core_output_addr  = OUT_BASE;
  assign res_nonce                 = res_nonce_q;
  assign res_hash                  = res_hash_q;
  assign res_found                 = res_found_q;
  assign res_timeout               = res_timeout_q;

endmodule
